// File: rtl/uart_alici_pkg.sv
// Shared UART constants: line levels and the receiver FSM state encoding.
package uart_alici_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam logic [2:0] BOSTA   = 3'd0;
    localparam logic [2:0] BASLA   = 3'd1;
    localparam logic [2:0] VERI_AL = 3'd2;
    localparam logic [2:0] DUR     = 3'd3;
    localparam logic [2:0] BEKLE   = 3'd4;

    localparam int VERI_W = 8;

endpackage

// File: rtl/uart_alici_senkronlayici.sv
// Multi-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so idle-high lines do not look active out of reset.
module senkronlayici #(
    parameter int   DERINLIK  = 2,
    parameter logic SIFIRLAMA = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DERINLIK-1:0] zincir;

    always_ff @(posedge clk) begin
        if (rst) zincir <= {DERINLIK{SIFIRLAMA}};
        else     zincir <= {zincir[DERINLIK-2:0], d};
    end

    assign q = zincir[DERINLIK-1];

endmodule

// File: rtl/uart_alici.sv
// UART 8N1 receiver: oversampling-free mid-bit sampling driven by a bit-period
// counter, with FIFO push strobe and framing/overrun pulses.
module uart_alici
    import uart_alici_pkg::*;
#(
    parameter int SENK_DERINLIK = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_en_i,
    input  logic              rx_i,
    input  logic [15:0]       baud_div_i,
    input  logic              fifo_dolu_i,
    output logic [VERI_W-1:0] veri_o,
    output logic              veri_gecerli_o,
    output logic              cerceve_hatasi_o,
    output logic              tasma_o,
    output logic              mesgul_o
);

    logic rx_s;

    senkronlayici #(
        .DERINLIK (SENK_DERINLIK),
        .SIFIRLAMA(HIGH)
    ) u_senk (
        .clk(clk_i),
        .rst(rst_i),
        .d  (rx_i),
        .q  (rx_s)
    );

    logic [2:0]        durum, durum_n;
    logic [15:0]       sayac, sayac_n;
    logic [15:0]       bolen, yari;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [VERI_W-1:0] veri_r, veri_r_n;
    logic              strobe_n, ferr_n, ovr_n;

    // The divisor is frozen while a frame is in flight, so a mid-frame change
    // cannot push the counter past its equality target and stall the FSM.
    assign yari = bolen >> 1;

    always_comb begin
        durum_n   = durum;
        sayac_n   = sayac + 16'd1;
        bit_idx_n = bit_idx;
        veri_r_n  = veri_r;
        strobe_n  = 1'b0;
        ferr_n    = 1'b0;
        ovr_n     = 1'b0;
        case (durum)
            BOSTA: begin
                sayac_n = '0;
                if (rx_en_i && rx_s == LOW) durum_n = BASLA;
            end
            BASLA: begin
                if (sayac == yari) begin
                    sayac_n   = '0;
                    bit_idx_n = '0;
                    durum_n   = (rx_s == LOW) ? VERI_AL : BOSTA;
                end
            end
            VERI_AL: begin
                if (sayac == bolen) begin
                    sayac_n           = '0;
                    veri_r_n[bit_idx] = rx_s;
                    bit_idx_n         = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) durum_n = DUR;
                end
            end
            DUR: begin
                if (sayac == bolen) begin
                    sayac_n = '0;
                    if (rx_s == HIGH) begin
                        durum_n = BOSTA;
                        if (fifo_dolu_i) ovr_n    = 1'b1;
                        else             strobe_n = 1'b1;
                    end else begin
                        ferr_n  = 1'b1;
                        durum_n = BEKLE;
                    end
                end
            end
            BEKLE: begin
                // A held-low break must release before another start is armed.
                if (rx_s == HIGH) begin
                    durum_n = BOSTA;
                    sayac_n = '0;
                end
            end
            default: begin
                durum_n = BOSTA;
                sayac_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum            <= BOSTA;
            sayac            <= '0;
            bit_idx          <= '0;
            veri_r           <= '0;
            bolen            <= '0;
            veri_o           <= '0;
            veri_gecerli_o   <= 1'b0;
            cerceve_hatasi_o <= 1'b0;
            tasma_o          <= 1'b0;
            mesgul_o         <= 1'b0;
        end else begin
            durum            <= durum_n;
            sayac            <= sayac_n;
            bit_idx          <= bit_idx_n;
            veri_r           <= veri_r_n;
            if (durum == BOSTA) bolen <= baud_div_i;
            if (strobe_n)       veri_o <= veri_r;
            veri_gecerli_o   <= strobe_n;
            cerceve_hatasi_o <= ferr_n;
            tasma_o          <= ovr_n;
            mesgul_o         <= (durum_n != BOSTA);
        end
    end

endmodule

// File: doc/uart_alici.md
# uart_alici

UART receive half for the peripheral block, the mirror of the existing UART transmitter. Recovers 8N1 frames (start, 8 data bits LSB first, 1 stop) from the asynchronous `rx_i` pin using the same `baud_div_i` bit-period programming as the transmitter. Pushes each good byte into the receive FIFO with a one-cycle strobe, and reports framing and overrun errors to the UART status register.

## Interface
- `SENK_DERINLIK`, default 2: number of synchronizer flops on `rx_i`; must be at least 2.
- `clk_i`  input  1  system clock.
- `rst_i`  input  1  reset; synchronous, active-high.
- `rx_en_i`  input  1  receive enable, from the UART control register.
- `rx_i`  input  1  asynchronous serial line; idles high.
- `baud_div_i`  input  16  bit period is `baud_div_i + 1` clocks (same as the transmitter); must be at least 2.
- `fifo_dolu_i`  input  1  receive FIFO full.
- `veri_o`  output  8  last received byte; held until the next good frame.
- `veri_gecerli_o`  output  1  one-cycle push strobe to the receive FIFO.
- `cerceve_hatasi_o`  output  1  one-cycle pulse: stop bit sampled low.
- `tasma_o`  output  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `mesgul_o`  output  1  high whenever the FSM is not in BOSTA.

## Operation
- `rx_i` passes through `SENK_DERINLIK` flops, all reset to 1. The last flop is `rx_s`. All FSM decisions use `rx_s` only.
- Half-period value: `yari = baud_div_i >> 1`.
- `sayac` is 16 bits. It increments every cycle outside BOSTA and is cleared on every sample event and on every state entry. It is compared by equality only, so it never wraps in legal use.
- BOSTA: `sayac` = 0.
  - If `rx_en_i` and `rx_s` == 0, go to BASLA.
  - `rx_en_i` low keeps the block in BOSTA.
- BASLA, start-bit check:
  - When `sayac == yari`, sample `rx_s`.
  - `rx_s` == 0: go to VERI_AL with `sayac` = 0 and bit index = 0.
  - `rx_s` == 1: glitch. Return to BOSTA silently, no error.
- VERI_AL: when `sayac == baud_div_i`, store `rx_s` into `veri_r[bit index]`, clear `sayac`, increment the index. After bit 7, go to DUR.
- DUR: when `sayac == baud_div_i`, sample the stop bit.
  - `rx_s` == 1 and `fifo_dolu_i` == 0: load `veri_o`, pulse `veri_gecerli_o`, go to BOSTA.
  - `rx_s` == 1 and `fifo_dolu_i` == 1: pulse `tasma_o`. `veri_o` is not updated and nothing is pushed. Go to BOSTA.
  - `rx_s` == 0: pulse `cerceve_hatasi_o`, discard the byte, go to BEKLE.
- BEKLE: wait for `rx_s` == 1, then go to BOSTA. This keeps a held-low break from being decoded as repeated 0x00 frames.
- Dropping `rx_en_i` mid-frame does not abort the frame; it only blocks the next start.
- Changing `baud_div_i` mid-frame gives undefined data. The FSM must still return to BOSTA within two frame times.

## Timing
- Reset values: `veri_o` = 0x00, `veri_gecerli_o` = 0, `cerceve_hatasi_o` = 0, `tasma_o` = 0, `mesgul_o` = 0. State is BOSTA, `sayac` = 0, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame on the next edge. No error pulse is generated.
- All outputs are registered. Pulses last exactly one cycle.
- Latency, with D = `baud_div_i`, `SENK_DERINLIK` = 2, and E0 the first edge that captures `rx_i` low:
  - BASLA is entered at E2.
  - Data bit k (k = 0..7) is sampled at edge E(2 + yari + 1 + (k+1)(D+1)).
  - The result strobe is high in the cycle after edge E(3 + yari + 9(D+1)).
  - `mesgul_o` rises after E2 and falls together with the result strobe.
- The DUR-to-BOSTA transition allows a back-to-back start that begins exactly at the stop-bit end with no lost frame. Minimum stop length accepted is from the stop-bit midpoint onward.
- `fifo_dolu_i` is sampled only in the stop-sample cycle.

## Structure
- States BOSTA, BASLA, VERI_AL, DUR, BEKLE are 3-bit encoded. Their constants go in the shared UART constants header, alongside the transmitter's states.
- `HIGH`/`LOW` come from the existing shared header.
- One sub-module: `senkronlayici`, a parameterized multi-flop synchronizer with configurable reset value. It is reused by other asynchronous inputs.
- Expected size is about 150–200 RTL lines.

## Test plan
- D = 3, `rx_en_i` = 1, send 0xA5 as an ideal 8N1 frame at 4 clocks per bit → `veri_o` = 0xA5 and `veri_gecerli_o` high for exactly the one cycle after edge E40. `mesgul_o` is low after that.
- Send 0x55 then 0x0F back-to-back with a stop bit of exactly 4 clocks → two strobes 40 cycles apart, values 0x55 and 0x0F, no errors.
- Send a 1-clock low glitch on idle `rx_i` → no strobe, no error, back in BOSTA within yari + 4 cycles.
- Send 0x3C with the stop bit low, then hold `rx_i` low for 100 cycles → one `cerceve_hatasi_o` pulse, no strobe, `mesgul_o` high until `rx_i` returns high.
- Hold `fifo_dolu_i` = 1 and send 0x81 → one `tasma_o` pulse, no strobe, `veri_o` keeps its previous value.
- Assert `rst_i` for one cycle during bit 4 of a frame → all outputs 0 next cycle. The remainder of the interrupted frame does not produce a strobe. The next clean frame, 0x12, is received correctly.
